imem_boot_sequencer: RTL and testbench
======================================

Name: imem_boot_sequencer

Overview:
- Boot/run controller for the pipelined MIPS core.
- Accepts a program as a stream of 32-bit words over a valid/ready handshake and writes it into the core's instruction memory through its write port (write data, write enable, 11-bit word address).
- Holds the core's PC forced to a programmed start address while idle or loading, then releases the core for a bounded or unbounded number of cycles.
- Sits between the testbench/host loader and the core's instruction-write and PC-set pins.

Parameters:
- ADDR_W, 11, instruction-memory word-address width; depth is 2^ADDR_W.
- DATA_W, 32, instruction word width.
- CNT_W, 16, width of the run-cycle budget.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a load/run sequence; accepted only in IDLE.
- load_len  in  ADDR_W+1  number of words to load, 1..2^ADDR_W; sampled with load_start.
- start_pc  in  DATA_W  PC forced into the core; sampled with load_start.
- run_cycles  in  CNT_W  run budget in cycles, where 0 means unbounded; sampled with load_start.
- abort  in  1  forces a return to IDLE from any state.
- in_data  in  DATA_W  program word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- imem_wdata  out  DATA_W  to the core's instruction-input pin.
- imem_we  out  1  to the core's instruction-write-enable pin.
- imem_waddr  out  ADDR_W  to the core's write-address pin.
- pc_out  out  DATA_W  to the core's PC pin.
- pc_set  out  1  to the core's PC-set pin.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a bounded run completes.
- error  out  1  one-cycle pulse when load_start is rejected.

Behaviour:
- Reset values: state=IDLE; in_ready=0; imem_we=0; imem_wdata=0; imem_waddr=0; pc_out=0; pc_set=1; busy=0; done=0; error=0; all internal counters 0.
- All outputs are registered.
- pc_set is 1 in every state except RUN, so the core is frozen at pc_out while not running.
- States: IDLE, LOAD, ARM, RUN.
- IDLE:
  - load_start with load_len in 1..2^ADDR_W: latch len, start_pc, and run_cycles; set pc_out=start_pc; clear word counter wcnt; go to LOAD.
  - load_start with load_len=0 or load_len>2^ADDR_W: error=1 for one cycle; stay in IDLE.
  - load_start is ignored in every other state (no error pulse).
- LOAD:
  - in_ready=1 while wcnt<len.
  - On in_valid&in_ready (accept): the next cycle drives imem_we=1, imem_wdata=accepted word, imem_waddr=wcnt[ADDR_W-1:0]; wcnt increments.
  - Back-to-back accepts are allowed, giving one write per cycle.
  - Write latency is exactly 1 cycle after accept; imem_we is 0 in cycles with no accept.
  - On the accept that brings wcnt to len: in_ready drops the next cycle, and the state moves to ARM together with the final write.
  - The address never wraps, because len is bounded to 2^ADDR_W.
- ARM:
  - Lasts exactly one cycle, with pc_set=1 and pc_out=start_pc.
  - This guarantees the final write has landed and the core's PC register has captured start_pc.
  - Next state is RUN; the run counter rcnt is loaded with the latched run_cycles.
- RUN:
  - pc_set=0, so the core free-runs.
  - If the budget is nonzero, rcnt decrements each cycle. In the cycle rcnt reaches 1, the next state is IDLE with done=1 for that transition cycle and pc_set=1 again.
  - The core therefore runs exactly run_cycles cycles with pc_set=0.
  - If the budget is 0, the state stays in RUN until abort.
- abort, in any state:
  - Next state is IDLE; pc_set=1; in_ready=0; imem_we=0.
  - No done pulse.
  - Partially written memory is left as is.
  - abort has priority over every other event in the same cycle, including a final accept or rcnt expiry.
- Reset mid-operation: asynchronous return to the reset values; an in-flight write is dropped.
- pc_out holds its latched value until the next accepted load_start.

Test Plan:
- Load len=3 words {0x20080005,0x20090007,0x01095020}, start_pc=0, run_cycles=10, in_valid held high → imem_we high 3 consecutive cycles at addresses 0,1,2; one ARM cycle; pc_set low exactly 10 cycles; done pulses once; busy falls.
- Same load with in_valid toggling 1,0,1,0,1 → in_ready/handshake respected; writes occur only 1 cycle after each accept; addresses 0,1,2 with no gaps in numbering.
- load_len=0, then load_len=2049 → error pulse each time; state stays IDLE; pc_set stays 1; no writes.
- run_cycles=0 with a one-word load → pc_set stays low indefinitely (check 100 cycles); abort → IDLE next cycle, pc_set=1, done=0.
- Abort asserted in the same cycle as the final accept of a len=4 load → the 4th write is suppressed; IDLE; no ARM or RUN.
- rst asserted during LOAD after 2 writes → outputs return to reset values immediately; a subsequent load of len=2 at start_pc=0x40 works normally, with pc_out=0x40.

Source files
------------

// File: rtl/imem_boot_sequencer_if.sv
// Program-stream, instruction-memory write and PC-control signals shared between
// the host loader, the boot sequencer and the MIPS core.
interface imem_boot_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] imem_wdata;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] pc_out;
    logic              pc_set;

    // Host/core side: supplies program words, observes memory writes and PC control
    modport master (
        output in_data, in_valid,
        input  in_ready, imem_wdata, imem_we, imem_waddr, pc_out, pc_set
    );

    // Sequencer side
    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_wdata, imem_we, imem_waddr, pc_out, pc_set
    );
endinterface

// File: rtl/imem_boot_sequencer.sv
// Boot/run controller: streams a program into instruction memory, holds the core's
// PC at a start address while loading, then lets the core run for a cycle budget.
module imem_boot_sequencer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [ADDR_W:0]     load_len,
    input  logic [DATA_W-1:0]   start_pc,
    input  logic [CNT_W-1:0]    run_cycles,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                error,
    imem_boot_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [ADDR_W:0]   wcnt_inc;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic              pc_set_q, pc_set_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              accept;
    logic              len_ok;

    assign accept   = (state_q == LOAD) && bus.in_valid && in_ready_q;
    assign len_ok   = (load_len != '0) && (load_len <= MAX_LEN);
    assign wcnt_inc = wcnt_q + (ADDR_W+1)'(1);

    // Every output is the registered copy of its *_d value, so all decisions live here.
    // abort wins over everything, and leaves latched load parameters and pc_out alone.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        run_d      = run_q;
        rcnt_d     = rcnt_q;
        pc_d       = pc_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        in_ready_d = in_ready_q;
        pc_set_d   = pc_set_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            pc_set_d   = 1'b1;
            in_ready_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_d = 1'b0;
                    pc_set_d   = 1'b1;
                    if (load_start) begin
                        if (len_ok) begin
                            len_d      = load_len;
                            pc_d       = start_pc;
                            run_d      = run_cycles;
                            wcnt_d     = '0;
                            in_ready_d = 1'b1;
                            state_d    = LOAD;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    pc_set_d = 1'b1;
                    if (accept) begin
                        we_d       = 1'b1;
                        wdata_d    = bus.in_data;
                        waddr_d    = wcnt_q[ADDR_W-1:0];
                        wcnt_d     = wcnt_inc;
                        in_ready_d = (wcnt_inc < len_q);
                        if (wcnt_inc == len_q) begin
                            state_d = ARM;
                        end
                    end
                end
                ARM: begin
                    state_d  = RUN;
                    rcnt_d   = run_q;
                    pc_set_d = 1'b0;
                end
                RUN: begin
                    pc_set_d = 1'b0;
                    // A zero budget leaves rcnt at 0, which means run until aborted
                    if (rcnt_q != '0) begin
                        rcnt_d = rcnt_q - CNT_W'(1);
                        if (rcnt_q == CNT_W'(1)) begin
                            state_d  = IDLE;
                            done_d   = 1'b1;
                            pc_set_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; pc_set resets high so the core stays frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            run_q      <= '0;
            rcnt_q     <= '0;
            pc_q       <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            pc_set_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            run_q      <= run_d;
            rcnt_q     <= rcnt_d;
            pc_q       <= pc_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            pc_set_q   <= pc_set_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.pc_out     = pc_q;
    assign bus.pc_set     = pc_set_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed and randomized bench for imem_boot_sequencer; a scoreboard of accepted
// words predicts each memory write, and the run length is counted from pc_set.
module tb_imem_boot_sequencer;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [DATA_W-1:0] start_pc;
    logic [CNT_W-1:0]  run_cycles;
    logic              abort;
    logic              busy;
    logic              done;
    logic              error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] prog [0:2047];

    imem_boot_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_boot_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .start_pc   (start_pc),
        .run_cycles (run_cycles),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) prog[i] = $urandom;
    endtask

    task automatic start_load(input int len, input logic [31:0] pc, input int runc);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len);
        start_pc   = pc;
        run_cycles = CNT_W'(runc);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Full load/arm/run sequence; valid_mode 0=always, 1=alternate, 2=random.
    // runc==0 leaves the DUT running after confirming 100 free-run cycles.
    task automatic apply_stimulus(input int len, input logic [31:0] pc, input int runc, input int valid_mode);
        int  cnt = 0;
        int  cyc = 0;
        int  low = 0;
        int  prev_idx = 0;
        bit  prev_acc = 1'b0;
        bit  v;
        start_load(len, pc, runc);
        check_output("load_pc_out", bus.pc_out, pc);
        check_output("load_busy", {31'b0, busy}, 32'd1);
        check_output("load_pc_set", {31'b0, bus.pc_set}, 32'd1);
        while (cyc < 64 * len + 100) begin
            if (prev_acc) begin
                check_output("write_we", {31'b0, bus.imem_we}, 32'd1);
                check_output("write_addr", {21'b0, bus.imem_waddr}, prev_idx);
                check_output("write_data", bus.imem_wdata, prog[prev_idx]);
            end else begin
                check_output("idle_we", {31'b0, bus.imem_we}, 32'd0);
            end
            if (cnt == len) break;
            check_output("load_in_ready", {31'b0, bus.in_ready}, 32'd1);
            case (valid_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? prog[cnt] : $urandom;
            prev_acc = v;
            prev_idx = cnt;
            if (v) cnt++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check_output("load_complete", cnt, len);
        check_output("arm_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check_output("arm_pc_set", {31'b0, bus.pc_set}, 32'd1);
        check_output("arm_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check_output("run_we", {31'b0, bus.imem_we}, 32'd0);
        if (runc > 0) begin
            while (bus.pc_set === 1'b0 && low < runc + 5) begin
                if (done !== 1'b0) check_output("run_done_early", {31'b0, done}, 32'd0);
                low++;
                @(negedge clk);
            end
            check_output("run_length", low, runc);
            check_output("run_done", {31'b0, done}, 32'd1);
            check_output("run_busy_end", {31'b0, busy}, 32'd0);
            @(negedge clk);
            check_output("done_pulse", {31'b0, done}, 32'd0);
            check_output("idle_pc_out", bus.pc_out, pc);
        end else begin
            repeat (100) begin
                if (bus.pc_set !== 1'b0) low++;
                @(negedge clk);
            end
            check_output("freerun_pc_set", low, 0);
            check_output("freerun_busy", {31'b0, busy}, 32'd1);
        end
    endtask

    task automatic check_reject(input int len);
        start_load(len, 32'hDEAD_0000, 3);
        check_output("reject_error", {31'b0, error}, 32'd1);
        check_output("reject_busy", {31'b0, busy}, 32'd0);
        check_output("reject_pc_set", {31'b0, bus.pc_set}, 32'd1);
        check_output("reject_we", {31'b0, bus.imem_we}, 32'd0);
        @(negedge clk);
        check_output("reject_pulse", {31'b0, error}, 32'd0);
        check_output("reject_stay_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        load_start   = 1'b0;
        load_len     = '0;
        start_pc     = '0;
        run_cycles   = '0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        check_output("reset_pc_set", {31'b0, bus.pc_set}, 32'd1);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check_output("reset_pc_out", bus.pc_out, 32'd0);
        rst = 1'b0;

        // Reference program, streamed without gaps and then with alternating valid
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0007;
        prog[2] = 32'h0109_5020;
        apply_stimulus(3, 32'h0, 10, 0);
        apply_stimulus(3, 32'h0, 10, 1);

        check_reject(0);
        check_reject(2049);

        // Unbounded run, a load_start that must be ignored, then abort
        fill_random(1);
        apply_stimulus(1, $urandom, 0, 2);
        load_start = 1'b1;
        load_len   = '0;
        @(negedge clk);
        load_start = 1'b0;
        check_output("run_ignore_error", {31'b0, error}, 32'd0);
        check_output("run_ignore_pc_set", {31'b0, bus.pc_set}, 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_busy", {31'b0, busy}, 32'd0);
        check_output("abort_pc_set", {31'b0, bus.pc_set}, 32'd1);
        check_output("abort_done", {31'b0, done}, 32'd0);
        check_output("abort_in_ready", {31'b0, bus.in_ready}, 32'd0);

        // Abort colliding with the final accept of a 4-word load
        fill_random(4);
        start_load(4, 32'h100, 5);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = prog[i];
            if (i == 3) abort = 1'b1;
            @(negedge clk);
        end
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        check_output("abort_final_we", {31'b0, bus.imem_we}, 32'd0);
        check_output("abort_final_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check_output("abort_no_arm_busy", {31'b0, busy}, 32'd0);
        check_output("abort_no_run_pc_set", {31'b0, bus.pc_set}, 32'd1);
        check_output("abort_no_done", {31'b0, done}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            int len = $urandom_range(1, 16);
            fill_random(len);
            apply_stimulus(len, $urandom, $urandom_range(1, 20), 2);
        end

        // Full-depth load with the shortest nonzero budget
        fill_random(2048);
        apply_stimulus(2048, 32'h8000_0000, 1, 0);

        // Reset after two writes have landed
        fill_random(5);
        start_load(5, 32'h1234, 5);
        bus.in_valid = 1'b1;
        bus.in_data  = prog[0];
        @(negedge clk);
        bus.in_data = prog[1];
        @(negedge clk);
        bus.in_data = prog[2];
        rst = 1'b1;
        #1;
        check_output("rst_mid_we", {31'b0, bus.imem_we}, 32'd0);
        check_output("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check_output("rst_mid_busy", {31'b0, busy}, 32'd0);
        check_output("rst_mid_pc_set", {31'b0, bus.pc_set}, 32'd1);
        check_output("rst_mid_pc_out", bus.pc_out, 32'd0);
        check_output("rst_mid_waddr", {21'b0, bus.imem_waddr}, 32'd0);
        check_output("rst_mid_wdata", bus.imem_wdata, 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        fill_random(2);
        apply_stimulus(2, 32'h40, 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
